// File: rtl/backtrack_ctrl_if.sv
// rtl/backtrack_ctrl_if.sv - assign, backtrack and unassign handshake channels
interface backtrack_ctrl_if #(
  parameter int VAR_W = 16,
  parameter int LVL_W = 8
);
  logic             assign_valid;
  logic             assign_ready;
  logic [VAR_W-1:0] assign_var;
  logic             assign_val;
  logic             assign_is_decision;

  logic             bt_valid;
  logic             bt_ready;
  logic [LVL_W-1:0] bt_level;

  logic             unassign_valid;
  logic             unassign_ready;
  logic [VAR_W-1:0] unassign_var;
  logic             unassign_val;

  // Solver side: issues assignments and backtrack requests, consumes unassigns
  modport master (
    output assign_valid, assign_var, assign_val, assign_is_decision,
    input  assign_ready,
    output bt_valid, bt_level,
    input  bt_ready,
    input  unassign_valid, unassign_var, unassign_val,
    output unassign_ready
  );

  // Controller side
  modport slave (
    input  assign_valid, assign_var, assign_val, assign_is_decision,
    output assign_ready,
    input  bt_valid, bt_level,
    output bt_ready,
    output unassign_valid, unassign_var, unassign_val,
    input  unassign_ready
  );
endinterface

// File: rtl/backtrack_ctrl.sv
// rtl/backtrack_ctrl.sv - trail push and non-chronological backtrack controller
module backtrack_ctrl #(
  parameter int VAR_W   = 16,
  parameter int LVL_W   = 8,
  parameter int ENTRY_W = VAR_W + LVL_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  backtrack_ctrl_if.slave    bus,
  output logic               bt_done,
  output logic [LVL_W-1:0]   cur_level,
  output logic               err_lvl_ovf,
  input  logic               clear,
  output logic               stk_push,
  output logic [ENTRY_W-1:0] stk_push_data,
  output logic               stk_pop,
  output logic               stk_clear,
  input  logic [ENTRY_W-1:0] stk_top_data,
  input  logic               stk_full,
  input  logic               stk_empty
);
  typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [LVL_W-1:0] target;
  logic [LVL_W-1:0] top_level;
  logic [LVL_W-1:0] push_level;
  logic             idle_ok;
  logic             bt_fire;
  logic             assign_fire;
  logic             dec_ovf;
  logic             push_fire;
  logic             pop_stop;

  // Trail entry layout is {level, var, val}; the level field sits in the MSBs
  assign top_level  = stk_top_data[ENTRY_W-1 -: LVL_W];
  assign push_level = bus.assign_is_decision ? cur_level + 1'b1 : cur_level;

  // Handshakes only open in IDLE; a pending backtrack blocks new assignments
  assign idle_ok          = !rst && !clear && (state == IDLE);
  assign bus.bt_ready     = idle_ok;
  assign bus.assign_ready = idle_ok && !bus.bt_valid && !stk_full;
  assign bt_fire          = bus.bt_valid && bus.bt_ready;
  assign assign_fire      = bus.assign_valid && bus.assign_ready;
  assign dec_ovf          = assign_fire && bus.assign_is_decision && (cur_level == {LVL_W{1'b1}});
  assign push_fire        = assign_fire && !dec_ovf;

  // Popping stops once the stack is exhausted or the top belongs to a kept level
  assign pop_stop = stk_empty || (top_level <= target);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; clear aborts from any state
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bt_fire) state_nxt = (bus.bt_level >= cur_level) ? DONE : POP;
        POP:     if (pop_stop) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs; everything handshake- or stack-facing is held low during rst
  always_comb begin
    bus.unassign_valid = 1'b0;
    bus.unassign_var   = stk_top_data[VAR_W:1];
    bus.unassign_val   = stk_top_data[0];
    bt_done            = 1'b0;
    stk_push           = 1'b0;
    stk_push_data      = {push_level, bus.assign_var, bus.assign_val};
    stk_pop            = 1'b0;
    stk_clear          = 1'b0;
    if (!rst) begin
      stk_clear = clear;
      if (!clear) begin
        case (state)
          IDLE: stk_push = push_fire;
          POP: begin
            bus.unassign_valid = !pop_stop;
            stk_pop            = !pop_stop && bus.unassign_ready;
          end
          DONE:    bt_done = 1'b1;
          default: bt_done = 1'b0;
        endcase
      end
    end
  end

  // Decision level, overflow flag and latched backtrack target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_level   <= '0;
      err_lvl_ovf <= 1'b0;
      target      <= '0;
    end else if (clear) begin
      cur_level   <= '0;
      err_lvl_ovf <= 1'b0;
      target      <= '0;
    end else begin
      if (bt_fire) target <= bus.bt_level;
      if (push_fire && bus.assign_is_decision) cur_level <= cur_level + 1'b1;
      if (dec_ovf) err_lvl_ovf <= 1'b1;
      if (state == DONE && target < cur_level) cur_level <= target;
    end
  end
endmodule
